mem_arbiter: RTL and testbench

//  Arbiter between the multicycle datapath's instruction-fetch (I) and data (D) request ports.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the instruction-fetch (I) and data (D) request
// ports of the multicycle datapath onto one single-ported unified memory.
// Each granted access runs IDLE -> ACCESS -> RESP and answers with a
// one-cycle ack. Ties are broken round-robin, starting with I after reset.
//
// Optional feature: define MEM_ARB_MISALIGN_EN to flag odd byte addresses.
// Such an access still spends its ACCESS cycle, but never writes, returns
// rdata=0 and raises err with the ack. Without the macro err is tied low and
// an odd address simply reaches the even word (the memory ignores bit 0).

module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  // instruction fetch port (read only)
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  // shared response
  output logic [DW-1:0] rdata,
  output logic          err,
  // memory side
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last_d;   // 1: the most recent grant went to D
  logic          r_gnt_d;    // port owning the access in flight
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          r_i_ack;
  logic          r_d_ack;

  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_misalign;

  // I wins when it asks alone, or on a tie when D was served last.
  assign w_grant_i = i_req && (!d_req || r_last_d);
  assign w_grant_d = d_req && !w_grant_i;

`ifdef MEM_ARB_MISALIGN_EN
  assign w_misalign = r_addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  // Memory bus straight from the latched access registers.
  assign mem_a  = r_addr;
  assign mem_wd = r_wd;
  // NOTE: mem_we is decoded from state rather than registered, so asserting
  // reset_n during ACCESS removes the write strobe at once and the pending
  // store can never commit at the following clock edge.
  assign mem_we = (r_state == S_ACCESS) && r_we && !w_misalign;

  assign rdata = r_rdata;
  assign err   = r_err;
  assign i_ack = r_i_ack;
  assign d_ack = r_d_ack;

  // Arbitration FSM: grant and latch in IDLE, capture the result at the end
  // of ACCESS, pulse the owner's ack during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every state element here is a flop updated with non-blocking
    // assignments; the reset branch clears all of them asynchronously.
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b1;
      r_gnt_d  <= 1'b0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wd     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req || d_req) begin
            r_gnt_d  <= w_grant_d;
            r_last_d <= w_grant_d;
            r_addr   <= w_grant_d ? d_addr : i_addr;
            r_we     <= w_grant_d && d_we;
            r_wd     <= w_grant_d ? d_wdata : '0;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Stores and flagged accesses return zero; loads take the word.
          r_rdata <= (r_we || w_misalign) ? '0 : mem_rd;
          r_err   <= w_misalign;
          r_i_ack <= !r_gnt_d;
          r_d_ack <= r_gnt_d;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 64x16 behavioural
// memory (combinational read, write on posedge). Expectations follow the
// MEM_ARB_MISALIGN_EN setting of the build.

module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] rdata;
  logic        err;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [15:0] mem_wd;
  logic [15:0] mem_rd;

  int total = 0;
  int bad   = 0;

`ifdef MEM_ARB_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .rdata   (rdata),
    .err     (err),
    .mem_a   (mem_a),
    .mem_we  (mem_we),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  // Behavioural unified memory.
  logic [15:0] mem [64];
  assign mem_rd = mem[mem_a[6:1]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[6:1]] <= mem_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/ack handshake on a single port; lat = edges to ack, -1 on timeout.
  task automatic do_access(input logic is_i, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, output int lat);
    bit got;
    got = 0;
    lat = -1;
    if (is_i) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end
    for (int c = 1; c <= 10 && !got; c++) begin
      tick();
      if (is_i ? i_ack : d_ack) begin
        got = 1;
        lat = c;
        check("other_ack", is_i ? d_ack : i_ack, 0);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  typedef struct {
    logic        is_i;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_err;
    logic        chk_mem;
    int          idx;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat;
    int n;
    int prev;
    int seen;

    vecs[0] = '{1'b1, 1'b0, 16'h000A, 16'h0000, 16'h2067, 1'b0, 1'b0, 0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 16, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 0, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'h0003, 16'h0000, MIS ? 16'h0000 : 16'h1111, MIS, 1'b0, 0, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 16'h0003, 16'hABCD, 16'h0000, MIS, 1'b1, 1, MIS ? 16'h1111 : 16'hABCD};
    vecs[6] = '{1'b1, 1'b0, 16'h0002, 16'h0000, MIS ? 16'h1111 : 16'hABCD, 1'b0, 1'b0, 0, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 16'h0002, 16'h7777, 16'h0000, 1'b0, 1'b1, 1, 16'h7777};
    vecs[8] = '{1'b1, 1'b0, 16'h0003, 16'h0000, MIS ? 16'h0000 : 16'h7777, MIS, 1'b0, 0, 16'h0000};
    vecs[9] = '{1'b0, 1'b0, 16'h000A, 16'h0000, 16'h2067, 1'b0, 1'b0, 0, 16'h0000};

    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[1] = 16'h1111;
    mem[5] = 16'h2067;
    mem[8] = 16'h5555;

    // Reset with a pending store held on D.
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = 16'h0000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hDEAD;
    tick();
    tick();
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_mem_a", mem_a, 0);
    reset_n = 1'b1;
    seen = -1;
    for (int c = 1; c <= 10 && seen < 0; c++) begin
      tick();
      if (d_ack) seen = c;
    end
    check("rst_first_lat", seen, 2);
    check("rst_first_rdata", rdata, 0);
    d_req = 1'b0;
    tick();
    check("rst_first_word", mem[32], 16'hDEAD);

    // Table of single-port accesses.
    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].is_i, vecs[i].we, vecs[i].addr, vecs[i].wd, lat);
      check($sformatf("v%0d_lat", i), lat, 2);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      tick();
      if (vecs[i].chk_mem) check($sformatf("v%0d_mem", i), mem[vecs[i].idx], vecs[i].exp_word);
    end

    // rdata/err hold while idle and inputs wiggle without a request.
    d_addr = 16'h0020; i_addr = 16'h0002;
    for (int c = 0; c < 4; c++) tick();
    check("hold_rdata", rdata, 16'h2067);
    check("hold_err", err, 0);
    check("idle_mem_we", mem_we, 0);

    // Contention after reset: I,D,I,D... three cycles apart.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 16'h000A;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    n = 0;
    prev = 0;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      tick();
      if (i_ack || d_ack) begin
        check($sformatf("cont%0d_both", n), i_ack && d_ack, 0);
        check($sformatf("cont%0d_port", n), d_ack, n % 2);
        check($sformatf("cont%0d_gap", n), c - prev, (n == 0) ? 2 : 3);
        check($sformatf("cont%0d_rdata", n), rdata, (n % 2) ? 16'hBEEF : 16'h2067);
        prev = c;
        n++;
      end
    end
    check("cont_count", n, 8);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();

    // Reset arriving during the ACCESS cycle of a store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
    tick();
    check("mid_store_mem_we", mem_we, 1);
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    check("mid_rst_mem_we", mem_we, 0);
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) reset_n = 1'b1;
      if (d_ack || i_ack) seen++;
    end
    check("mid_rst_no_ack", seen, 0);
    check("mid_rst_word8", mem[8], 16'h5555);
    check("mid_rst_rdata", rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
